// File: rtl/uart_pg_pkg.sv
// Shared types and constants for the UART program-image loader.
package uart_pg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_L,
    ST_CNT_H,
    ST_DAT_L,
    ST_DAT_H,
    ST_CHK,
    ST_DONE
  } pg_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // sync byte + 16-bit word count
  localparam int HDR_LEN = 3;

  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, start detect with mid-bit glitch reject, byte/framing strobes.
module uart_rx_byte #(
  parameter int BIT_CYC = 86
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = 16;
  localparam logic [TW-1:0] FULL_LD = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] HALF_LD = TW'(BIT_CYC / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e       state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            tmr_zero;

  // Synchroniser flops reset to the idle level so reset release cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          tmr_d   = HALF_LD;
        end
      end
      RX_START: begin
        if (!tmr_zero) begin
          tmr_d = tmr_q - 1'b1;
        end else if (sync2_q) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          tmr_d   = FULL_LD;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (!tmr_zero) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          shift_d = {sync2_q, shift_q[7:1]};
          tmr_d   = FULL_LD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!tmr_zero) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          state_d = RX_IDLE;
          if (sync2_q) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_pg_loader.sv
// Frame parser driving the memory program-download write bus from a UART byte stream.
// Define PG_CHECKSUM_EN to require a trailing mod-256 checksum byte before pg_done.
//
// state    | meaning
// IDLE     | waiting for sync byte
// CNT_L/H  | collecting 16-bit word count N
// DAT_L/H  | collecting low/high data byte; write issued after high byte
// CHK      | comparing checksum byte (PG_CHECKSUM_EN only)
// DONE     | image complete, pg_done held
module uart_pg_loader
  import uart_pg_pkg::*;
#(
  parameter int         CLK_HZ    = 10000000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        pg_clk_i,
  input  logic        pg_rst_i,
  input  logic        uart_rxd,
  output logic        pg_wen,
  output logic [15:0] pg_din,
  output logic [15:0] pg_adr,
  output logic        pg_done,
  output logic        pg_err
);

  localparam int BIT_CYC = bit_cycles(CLK_HZ, BAUD);

`ifdef PG_CHECKSUM_EN
  localparam pg_state_e END_ST = ST_CHK;
`else
  localparam pg_state_e END_ST = ST_DONE;
`endif

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk        (pg_clk_i),
    .rst        (pg_rst_i),
    .rxd        (uart_rxd),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  pg_state_e   state_q, state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] remain_q, remain_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] adr_q, adr_d;
  logic        wen_q, wen_d;
  logic [15:0] din_q, din_d;
  logic [15:0] wadr_q, wadr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef PG_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif
  logic        is_sync;

  always_ff @(posedge pg_clk_i) begin
    if (pg_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_lo_q <= '0;
      remain_q <= '0;
      lo_q     <= '0;
      adr_q    <= '0;
      wen_q    <= 1'b0;
      din_q    <= '0;
      wadr_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PG_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      remain_q <= remain_d;
      lo_q     <= lo_d;
      adr_q    <= adr_d;
      wen_q    <= wen_d;
      din_q    <= din_d;
      wadr_q   <= wadr_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PG_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign is_sync = rx_valid && (rx_byte == SYNC_BYTE);

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    remain_d = remain_q;
    lo_d     = lo_q;
    adr_d    = adr_q;
    wen_d    = 1'b0;
    din_d    = din_q;
    wadr_d   = wadr_q;
    err_d    = err_q;
`ifdef PG_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Framing errors and stray bytes are ignored while no frame is open.
        if (is_sync) begin
          state_d = ST_CNT_L;
          err_d   = 1'b0;
          adr_d   = '0;
`ifdef PG_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_CNT_L: begin
        if (rx_valid) begin
          cnt_lo_d = rx_byte;
          state_d  = ST_CNT_H;
        end
      end
      ST_CNT_H: begin
        if (rx_valid) begin
          remain_d = {rx_byte, cnt_lo_q};
          state_d  = ({rx_byte, cnt_lo_q} == 16'd0) ? END_ST : ST_DAT_L;
        end
      end
      ST_DAT_L: begin
        if (rx_valid) begin
          lo_d    = rx_byte;
          state_d = ST_DAT_H;
`ifdef PG_CHECKSUM_EN
          sum_d   = sum_q + rx_byte;
`endif
        end
      end
      ST_DAT_H: begin
        if (rx_valid) begin
          wen_d    = 1'b1;
          din_d    = {rx_byte, lo_q};
          wadr_d   = adr_q;
          adr_d    = adr_q + 16'd1;
          remain_d = remain_q - 16'd1;
          state_d  = (remain_q == 16'd1) ? END_ST : ST_DAT_L;
`ifdef PG_CHECKSUM_EN
          sum_d    = sum_q + rx_byte;
`endif
        end
      end
`ifdef PG_CHECKSUM_EN
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_byte == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (rx_ferr && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end

    // pg_done follows the state one cycle late, so a re-arming sync drops it the next cycle.
    done_d = (state_d == ST_DONE);
  end

  assign pg_wen  = wen_q;
  assign pg_din  = din_q;
  assign pg_adr  = wadr_q;
  assign pg_done = done_q;
  assign pg_err  = err_q;

endmodule
